// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: word type, reset constants
// and the sequential-address helper.
package if_stage_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'hBFC0_0000;
  localparam word_t DEFAULT_NOP_WORD = 32'h0000_0000;
  localparam word_t PC_STEP          = 32'd4;

  // Modular add: 32'hFFFF_FFFC wraps to zero.
  function automatic word_t next_seq(input word_t addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control from ID/MEM, instruction-memory port and the
// IF/ID pipeline register outputs.
interface if_stage_if;
  import if_stage_pkg::*;

  logic  STALL;
  logic  Request_Alt_PC;
  word_t Alt_PC;
  word_t Instr_address_2IM;
  word_t Instr1_fIM;
  word_t Instr1_OUT;
  word_t Instr_PC_OUT;
  word_t Instr_PC_Plus4;

  modport master (
    input  STALL, Request_Alt_PC, Alt_PC, Instr1_fIM,
    output Instr_address_2IM, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4
  );

  modport slave (
    output STALL, Request_Alt_PC, Alt_PC, Instr1_fIM,
    input  Instr_address_2IM, Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4
  );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, stalled-redirect latch and the IF/ID
// pipeline register. The fetch address is combinational from these.
module if_stage
  import if_stage_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC,
  parameter word_t NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic       CLK,
  input  logic       RESET,
  if_stage_if.master bus
);

  word_t pc_q, pc_d;
  logic  pend_q, pend_d;
  word_t pend_pc_q, pend_pc_d;
  word_t instr_q, instr_d;
  word_t instr_pc_q, instr_pc_d;
  word_t instr_pc4_q, instr_pc4_d;
  word_t fetch_addr;
  word_t fetch_addr_p4;

  // A live redirect beats a held one, which beats sequential fetch.
  always_comb begin
    if (bus.Request_Alt_PC) begin
      fetch_addr = bus.Alt_PC;
    end else if (pend_q) begin
      fetch_addr = pend_pc_q;
    end else begin
      fetch_addr = pc_q;
    end
    fetch_addr_p4 = next_seq(fetch_addr);
  end

  always_comb begin
    pc_d        = pc_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    instr_pc4_d = instr_pc4_q;
    if (!bus.STALL) begin
      instr_d     = bus.Instr1_fIM;
      instr_pc_d  = fetch_addr;
      instr_pc4_d = fetch_addr_p4;
      pc_d        = fetch_addr_p4;
      pend_d      = 1'b0;
    end else if (bus.Request_Alt_PC) begin
      // Newest redirect during a stall overwrites any earlier one.
      pend_d    = 1'b1;
      pend_pc_d = bus.Alt_PC;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      pc_q        <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      instr_q     <= NOP_WORD;
      instr_pc_q  <= '0;
      instr_pc4_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      instr_q     <= instr_d;
      instr_pc_q  <= instr_pc_d;
      instr_pc4_q <= instr_pc4_d;
    end
  end

  assign bus.Instr_address_2IM = fetch_addr;
  assign bus.Instr1_OUT        = instr_q;
  assign bus.Instr_PC_OUT      = instr_pc_q;
  assign bus.Instr_PC_Plus4    = instr_pc4_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run, all checked
// against a transaction-level fetch model kept here.
module tb_if_stage;
  import if_stage_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   failures = 0;

  if_stage_if bus ();

  if_stage dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: fixed word at BFC00004, scrambled address elsewhere.
  function automatic word_t mem_word(input word_t a);
    if (a == 32'hBFC0_0004) return 32'h2108_0001;
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign bus.Instr1_fIM = mem_word(bus.Instr_address_2IM);

  // Reference model state.
  word_t m_pc, m_pend_pc, m_instr, m_pc_out, m_plus4;
  bit    m_pend;

  task automatic model_reset();
    m_pc = 32'hBFC0_0000; m_pend = 0; m_pend_pc = 0;
    m_instr = 32'h0; m_pc_out = 0; m_plus4 = 0;
  endtask

  // One clock: apply inputs, sample address mid-cycle, step the model after the edge.
  task automatic drive_cycle(input bit rst_n, input bit stall, input bit req, input word_t alt,
                             output word_t seen, output word_t expd);
    RESET = rst_n;
    bus.STALL = stall;
    bus.Request_Alt_PC = req;
    bus.Alt_PC = alt;
    #1;
    seen = bus.Instr_address_2IM;
    expd = req ? alt : (m_pend ? m_pend_pc : m_pc);
    @(posedge CLK);
    #1;
    if (!rst_n) begin
      model_reset();
    end else if (!stall) begin
      m_instr = mem_word(expd);
      m_pc_out = expd;
      m_plus4 = expd + 32'd4;
      m_pc = expd + 32'd4;
      m_pend = 0;
    end else if (req) begin
      m_pend = 1;
      m_pend_pc = alt;
    end
  endtask

  task automatic test_reset();
    word_t s, e;
    word_t exp_a[3];
    exp_a[0] = 32'hBFC0_0000; exp_a[1] = 32'hBFC0_0004; exp_a[2] = 32'hBFC0_0008;
    model_reset();
    drive_cycle(0, 0, 0, 0, s, e);
    drive_cycle(0, 0, 1, 32'h1234_5678, s, e);
    checks++;
    if (bus.Instr1_OUT !== 32'h0 || bus.Instr_PC_OUT !== 32'h0 || bus.Instr_PC_Plus4 !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs: got %h/%h/%h want 0/0/0", bus.Instr1_OUT, bus.Instr_PC_OUT, bus.Instr_PC_Plus4);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1, 0, 0, 0, s, e);
      checks++;
      if (s !== exp_a[i]) begin
        failures++;
        $display("FAIL reset_seq_addr[%0d]: got %h want %h", i, s, exp_a[i]);
      end
      checks++;
      if (bus.Instr_PC_Plus4 !== exp_a[i] + 32'd4 || bus.Instr_PC_OUT !== exp_a[i]) begin
        failures++;
        $display("FAIL reset_seq_out[%0d]: got pc=%h pc4=%h want pc=%h", i, bus.Instr_PC_OUT, bus.Instr_PC_Plus4, exp_a[i]);
      end
    end
  endtask

  task automatic test_stall();
    word_t s, e;
    drive_cycle(0, 0, 0, 0, s, e);
    drive_cycle(1, 0, 0, 0, s, e);
    drive_cycle(1, 0, 0, 0, s, e);
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1, 1, 0, 0, s, e);
      checks++;
      if (s !== 32'hBFC0_0008) begin
        failures++;
        $display("FAIL stall_addr[%0d]: got %h want bfc00008", i, s);
      end
      checks++;
      if (bus.Instr1_OUT !== 32'h2108_0001 || bus.Instr_PC_OUT !== 32'hBFC0_0004 ||
          bus.Instr_PC_Plus4 !== 32'hBFC0_0008) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%h want 21080001/bfc00004/bfc00008",
                 i, bus.Instr1_OUT, bus.Instr_PC_OUT, bus.Instr_PC_Plus4);
      end
    end
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (s !== 32'hBFC0_0008 || bus.Instr_PC_OUT !== 32'hBFC0_0008) begin
      failures++;
      $display("FAIL stall_release: got addr=%h pc=%h want bfc00008", s, bus.Instr_PC_OUT);
    end
  endtask

  task automatic test_redirect();
    word_t s, e;
    drive_cycle(1, 0, 1, 32'h0040_0100, s, e);
    checks++;
    if (s !== 32'h0040_0100 || bus.Instr_PC_OUT !== 32'h0040_0100) begin
      failures++;
      $display("FAIL redirect: got addr=%h pc=%h want 00400100", s, bus.Instr_PC_OUT);
    end
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (s !== 32'h0040_0104) begin
      failures++;
      $display("FAIL redirect_next: got %h want 00400104", s);
    end
  endtask

  task automatic test_stalled_redirects();
    word_t s, e;
    drive_cycle(1, 1, 1, 32'h0040_0200, s, e);
    drive_cycle(1, 1, 1, 32'h0040_0300, s, e);
    drive_cycle(1, 1, 0, 0, s, e);
    checks++;
    if (s !== 32'h0040_0300) begin
      failures++;
      $display("FAIL stalled_redir_addr: got %h want 00400300", s);
    end
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (bus.Instr_PC_OUT !== 32'h0040_0300) begin
      failures++;
      $display("FAIL stalled_redir_out: got %h want 00400300", bus.Instr_PC_OUT);
    end
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (s !== 32'h0040_0304) begin
      failures++;
      $display("FAIL stalled_redir_next: got %h want 00400304", s);
    end
  endtask

  task automatic test_release_with_redirect();
    word_t s, e;
    drive_cycle(1, 1, 1, 32'h0040_0600, s, e);
    drive_cycle(1, 0, 1, 32'h0040_0700, s, e);
    checks++;
    if (s !== 32'h0040_0700 || bus.Instr_PC_OUT !== 32'h0040_0700) begin
      failures++;
      $display("FAIL release_redir: got addr=%h pc=%h want 00400700", s, bus.Instr_PC_OUT);
    end
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (s !== 32'h0040_0704) begin
      failures++;
      $display("FAIL release_redir_next: got %h want 00400704", s);
    end
  endtask

  task automatic test_wrap();
    word_t s, e;
    drive_cycle(1, 0, 1, 32'hFFFF_FFFC, s, e);
    checks++;
    if (bus.Instr_PC_Plus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_plus4: got %h want 00000000", bus.Instr_PC_Plus4);
    end
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (s !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: got %h want 00000000", s);
    end
  endtask

  task automatic test_reset_pending();
    word_t s, e;
    drive_cycle(1, 1, 1, 32'h0040_0500, s, e);
    drive_cycle(0, 1, 0, 0, s, e);
    drive_cycle(1, 0, 0, 0, s, e);
    checks++;
    if (s !== 32'hBFC0_0000) begin
      failures++;
      $display("FAIL reset_pending: got %h want bfc00000", s);
    end
  endtask

  task automatic test_random();
    word_t s, e;
    bit rst_n, stall, req;
    word_t alt;
    drive_cycle(0, 0, 0, 0, s, e);
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      stall = ($urandom_range(0, 9) < 4);
      req   = ($urandom_range(0, 9) < 2);
      alt   = $urandom();
      drive_cycle(rst_n, stall, req, alt, s, e);
      checks++;
      if (s !== e) begin
        failures++;
        $display("FAIL rand_addr[%0d]: got %h want %h", i, s, e);
      end
      checks++;
      if (bus.Instr1_OUT !== m_instr || bus.Instr_PC_OUT !== m_pc_out || bus.Instr_PC_Plus4 !== m_plus4) begin
        failures++;
        $display("FAIL rand_out[%0d]: got %h/%h/%h want %h/%h/%h", i, bus.Instr1_OUT, bus.Instr_PC_OUT,
                 bus.Instr_PC_Plus4, m_instr, m_pc_out, m_plus4);
      end
    end
  endtask

  initial begin
    RESET = 1'b0;
    bus.STALL = 1'b0;
    bus.Request_Alt_PC = 1'b0;
    bus.Alt_PC = '0;
    test_reset();
    test_stall();
    test_redirect();
    test_stalled_redirects();
    test_release_with_redirect();
    test_wrap();
    test_reset_pending();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core. It holds the program counter and drives the instruction-memory address combinationally. On each unstalled clock it registers the fetched word, its PC and PC+4 into the IF/ID pipeline register. It accepts a late PC redirect from the MEM stage, which wins over sequential fetch. A redirect that arrives while the stage is stalled is held and applied at the first unstalled edge.

## Interface
Parameters:
- RESET_PC, default 32'hBFC0_0000: first fetch address after reset.
- NOP_WORD, default 32'h0000_0000: instruction word presented downstream during reset.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- RESET  in  1  one clock; reset is synchronous and active-low.
- STALL  in  1  freeze request from ID; when high, PC and outputs hold.
- Request_Alt_PC  in  1  redirect request from MEM, valid for one cycle.
- Alt_PC  in  32  redirect target, qualified by Request_Alt_PC.
- Instr_address_2IM  out  32  fetch address to instruction memory (combinational).
- Instr1_fIM  in  32  word returned by instruction memory for Instr_address_2IM in the same cycle.
- Instr1_OUT  out  32  registered fetched instruction to ID.
- Instr_PC_OUT  out  32  registered address of Instr1_OUT.
- Instr_PC_Plus4  out  32  registered Instr_PC_OUT+4.

## Operation
- Internal state:
  - PC (32): next sequential fetch address.
  - pend (1): redirect-pending flag.
  - pend_pc (32): held redirect target.
- Fetch-address select, combinational, in priority order:
  - Request_Alt_PC=1 → Alt_PC.
  - else pend=1 → pend_pc.
  - else PC.
- Rising edge, RESET=0:
  - PC=RESET_PC, pend=0, pend_pc=0.
  - Instr1_OUT=NOP_WORD, Instr_PC_OUT=0, Instr_PC_Plus4=0.
- Rising edge, RESET=1, STALL=0:
  - Instr1_OUT←Instr1_fIM, Instr_PC_OUT←addr, Instr_PC_Plus4←addr+4.
  - PC←addr+4, pend←0.
- Rising edge, RESET=1, STALL=1:
  - Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4 and PC hold.
  - If Request_Alt_PC=1: pend←1, pend_pc←Alt_PC. If several redirects arrive during one stall, the newest wins.
  - Otherwise pend and pend_pc hold.
- Arithmetic: addr+4 is a 32-bit modular add; 32'hFFFF_FFFC wraps to 0.
- No alignment check: Alt_PC low bits pass through unchanged.
- Squashing wrong-path instructions already in downstream stages is not this block's job.

## Timing
- Fetch-to-output latency is 1 cycle: the address driven in cycle n appears on Instr_PC_OUT after edge n.
- A redirect in unstalled cycle n: Alt_PC is fetched in cycle n; Alt_PC+4 is fetched in cycle n+1.
- A redirect during a stall takes effect on the first cycle with STALL=0. Instr_address_2IM shows pend_pc throughout the stall.
- Redirect and STALL release in the same cycle: the redirect is used directly, and pend clears at that edge.
- Reset asserted mid-stall or with a pending redirect: the pending redirect is discarded.
- The first fetch after reset release is RESET_PC.

## Structure
- Shared pipeline package: RESET_PC and NOP_WORD constants, plus a 32-bit word/address typedef.
- Single flat module; no sub-module needed.
- The only state registers are the PC register, the redirect latch and the three output registers.

## Test plan
- Reset, then 3 unstalled cycles → Instr_address_2IM = BFC00000, BFC00004, BFC00008; Instr_PC_Plus4 = BFC00004… after each edge; during reset Instr1_OUT = 0.
- Memory returns 32'h2108_0001 at BFC00004; raise STALL for 2 cycles → outputs hold 2108_0001/BFC00004/BFC00008 and the address stays BFC00008; on release, fetch resumes at BFC00008.
- Request_Alt_PC=1, Alt_PC=0040_0100, unstalled → same-cycle address 00400100; next address 00400104; Instr_PC_OUT=00400100.
- Redirects to 00400200 then 00400300 while STALL=1 → address shows 00400300; after release Instr_PC_OUT=00400300 and the next fetch is 00400304.
- Alt_PC=FFFF_FFFC → Instr_PC_Plus4=0 and the next fetch address is 0.
- Pending redirect, then RESET low for 1 cycle → pend is cleared and the next fetch is BFC00000.
